rr2_issue_arbiter: RTL and testbench

//  Round-robin arbiter that grants up to two of WIDTH level-sensitive requesters per cycle.
//  It sits in front of a dual-ported shared resource (e.g. 2-wide issue/writeback slots).

---
 rtl/rr2_issue_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr2_issue_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr2_issue_arbiter.sv
// Two-grant round-robin issue arbiter: picks the first two eligible requesters in
// rotating priority order and holds them in a valid/ready output bundle.

module pe2_lsb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec,
  output logic                     valid0,
  output logic [$clog2(WIDTH)-1:0] idx0,
  output logic                     valid1,
  output logic [$clog2(WIDTH)-1:0] idx1
);
  localparam int IW = $clog2(WIDTH);

  // Scan high to low so the lowest set bit ends in slot 0 and the next one in slot 1.
  always_comb begin
    valid0 = 1'b0;
    valid1 = 1'b0;
    idx0   = '0;
    idx1   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx1   = idx0;
        valid1 = valid0;
        idx0   = IW'(i);
        valid0 = 1'b1;
      end
    end
  end
endmodule

module rr2_issue_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [WIDTH-1:0]         req_vec,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid0,
  output logic [$clog2(WIDTH)-1:0] out_index0,
  output logic                     out_valid1,
  output logic [$clog2(WIDTH)-1:0] out_index1,
  output logic [WIDTH-1:0]         ack_one_hot,
  output logic [$clog2(WIDTH)-1:0] rr_ptr
);
  localparam int IW = $clog2(WIDTH);

  logic          valid0_q, valid0_d, valid1_q, valid1_d;
  logic [IW-1:0] index0_q, index0_d, index1_q, index1_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0] held_mask, eligible, ptr_mask, masked;
  logic             m_v0, m_v1, u_v0, u_v1;
  logic [IW-1:0]    m_i0, m_i1, u_i0, u_i1;
  logic [IW-1:0]    sel0, sel1, last_sel;
  logic             load;

  always_comb begin
    held_mask = '0;
    if (valid0_q) begin
      held_mask[index0_q] = 1'b1;
      if (valid1_q) held_mask[index1_q] = 1'b1;
    end
  end

  always_comb begin
    ptr_mask = '0;
    for (int i = 0; i < WIDTH; i++) ptr_mask[i] = (i >= int'(ptr_q));
  end

  assign eligible = req_vec & ~held_mask;
  assign masked   = eligible & ptr_mask;

  pe2_lsb #(.WIDTH(WIDTH)) u_pe_masked (
    .vec(masked), .valid0(m_v0), .idx0(m_i0), .valid1(m_v1), .idx1(m_i1)
  );

  pe2_lsb #(.WIDTH(WIDTH)) u_pe_unmasked (
    .vec(eligible), .valid0(u_v0), .idx0(u_i0), .valid1(u_v1), .idx1(u_i1)
  );

  // With one masked hit, slot 1 wraps to the lowest eligible index; it can only
  // collide with slot 0 when nothing sits below rr_ptr, in which case slot 1 is invalid.
  always_comb begin
    if (m_v1) begin
      sel0 = m_i0;
      sel1 = m_i1;
    end else if (m_v0) begin
      sel0 = m_i0;
      sel1 = (u_i0 != m_i0) ? u_i0 : u_i1;
    end else begin
      sel0 = u_i0;
      sel1 = u_i1;
    end
    last_sel = u_v1 ? sel1 : sel0;
  end

  assign load        = !valid0_q || out_ready;
  assign ack_one_hot = (valid0_q && out_ready && !flush) ? held_mask : '0;

  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    index0_d = index0_q;
    index1_d = index1_q;
    ptr_d    = ptr_q;
    if (flush) begin
      valid0_d = 1'b0;
      valid1_d = 1'b0;
    end else if (load) begin
      valid0_d = u_v0;
      valid1_d = u_v1;
      if (u_v0) begin
        index0_d = sel0;
        ptr_d    = last_sel + IW'(1);
      end
      if (u_v1) index1_d = sel1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      index0_q <= '0;
      index1_q <= '0;
      ptr_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      index0_q <= index0_d;
      index1_q <= index1_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid0 = valid0_q;
  assign out_valid1 = valid1_q;
  assign out_index0 = index0_q;
  assign out_index1 = index1_q;
  assign rr_ptr     = ptr_q;
endmodule

// File: tb/tb_rr2_issue_arbiter.sv
// Bench for rr2_issue_arbiter: directed scenarios plus random traffic checked against
// a priority-walk reference model of the grant bundle.

module tb_rr2_issue_arbiter;
  localparam int W = 8;

  logic         CLK;
  logic         nRST;
  logic [W-1:0] req_vec;
  logic         flush;
  logic         out_ready;
  logic         out_valid0, out_valid1;
  logic [2:0]   out_index0, out_index1, rr_ptr;
  logic [W-1:0] ack_one_hot;

  int vectors;
  int miscompares;

  // Reference state
  logic       m_v0, m_v1;
  int         m_i0, m_i1, m_ptr;

  rr2_issue_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .req_vec(req_vec), .flush(flush), .out_ready(out_ready),
    .out_valid0(out_valid0), .out_index0(out_index0), .out_valid1(out_valid1),
    .out_index1(out_index1), .ack_one_hot(ack_one_hot), .rr_ptr(rr_ptr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_held();
    logic [W-1:0] h;
    h = '0;
    if (m_v0) begin
      h[m_i0] = 1'b1;
      if (m_v1) h[m_i1] = 1'b1;
    end
    return h;
  endfunction

  // Drive inputs, then compare everything visible before the next edge with the model.
  task automatic apply(input logic [W-1:0] r, input logic f, input logic rd, input logic rstn);
    logic [W-1:0] exp_ack;
    req_vec = r; flush = f; out_ready = rd; nRST = rstn;
    #1;
    exp_ack = (m_v0 && rd && !f) ? model_held() : '0;
    chk("valid0", out_valid0, m_v0);
    chk("valid1", out_valid1, m_v1);
    if (m_v0) chk("index0", out_index0, m_i0);
    if (m_v1) chk("index1", out_index1, m_i1);
    chk("rr_ptr", rr_ptr, m_ptr);
    chk("ack", ack_one_hot, exp_ack);
  endtask

  // Advance the model by one clock using the applied inputs, then clock the DUT.
  task automatic tick();
    logic [W-1:0] elig;
    int n, s0, s1, j;
    if (!nRST) begin
      m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_ptr = 0;
    end else if (flush) begin
      m_v0 = 0; m_v1 = 0;
    end else if (!m_v0 || out_ready) begin
      elig = req_vec & ~model_held();
      n = 0; s0 = 0; s1 = 0;
      for (int k = 0; k < W; k++) begin
        j = (m_ptr + k) % W;
        if (elig[j]) begin
          if (n == 0) s0 = j;
          else if (n == 1) s1 = j;
          n++;
        end
      end
      m_v0 = (n >= 1);
      m_v1 = (n >= 2);
      if (m_v0) begin
        m_i0  = s0;
        m_ptr = ((m_v1 ? s1 : s0) + 1) % W;
      end
      if (m_v1) m_i1 = s1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_bundle(input logic v0, input logic v1, input int i0, input int i1,
                               input int ptr);
    chk("dir_valid0", out_valid0, v0);
    chk("dir_valid1", out_valid1, v1);
    if (v0) chk("dir_index0", out_index0, i0);
    if (v1) chk("dir_index1", out_index1, i1);
    chk("dir_rr_ptr", rr_ptr, ptr);
  endtask

  initial begin
    logic [W-1:0] r;
    vectors = 0; miscompares = 0;
    m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_ptr = 0;
    nRST = 1'b0; req_vec = 8'hFF; flush = 1'b0; out_ready = 1'b1;
    @(posedge CLK);
    #1;

    // Reset with all requesting, then release
    apply(8'hFF, 0, 1, 0);
    chk("rst_ack", ack_one_hot, 8'h00);
    tick();
    expect_bundle(0, 0, 0, 0, 0);
    apply(8'hFF, 0, 1, 1);
    tick();
    expect_bundle(1, 1, 0, 1, 2);

    // Grant only 7 to bring the pointer back to 0
    apply(8'h80, 0, 1, 1);
    chk("ack_01", ack_one_hot, 8'h03);
    tick();
    expect_bundle(1, 0, 7, 0, 0);

    // Basic pair
    apply(8'b0001_0100, 0, 1, 1);
    chk("ack_7", ack_one_hot, 8'h80);
    tick();
    expect_bundle(1, 1, 2, 4, 5);

    // Wrap-around from pointer 5
    apply(8'b0000_1001, 0, 1, 1);
    chk("ack_24", ack_one_hot, 8'b0001_0100);
    tick();
    expect_bundle(1, 1, 0, 3, 4);
    apply(8'b0010_0000, 0, 1, 1);
    tick();
    expect_bundle(1, 0, 5, 0, 6);
    apply(8'b0100_0001, 0, 1, 1);
    tick();
    expect_bundle(1, 1, 6, 0, 1);

    // Stall three cycles, then accept
    for (int c = 0; c < 3; c++) begin
      apply(8'hFF, 0, 0, 1);
      chk("stall_ack", ack_one_hot, 8'h00);
      tick();
      expect_bundle(1, 1, 6, 0, 1);
    end
    apply(8'hFF, 0, 1, 1);
    chk("release_ack", ack_one_hot, 8'b0100_0001);
    tick();
    expect_bundle(1, 1, 1, 2, 3);

    // Single requester at the top, then idle
    apply(8'b0100_0000, 0, 1, 1);
    tick();
    expect_bundle(1, 0, 6, 0, 7);
    apply(8'b1000_0000, 0, 1, 1);
    tick();
    expect_bundle(1, 0, 7, 0, 0);
    apply(8'h00, 0, 1, 1);
    tick();
    expect_bundle(0, 0, 0, 0, 0);

    // Flush during stall, and flush against out_ready
    apply(8'h0C, 0, 1, 1);
    tick();
    expect_bundle(1, 1, 2, 3, 4);
    apply(8'hFF, 0, 0, 1);
    tick();
    apply(8'hFF, 1, 0, 1);
    chk("flush_stall_ack", ack_one_hot, 8'h00);
    tick();
    expect_bundle(0, 0, 0, 0, 4);
    apply(8'h30, 0, 1, 1);
    tick();
    expect_bundle(1, 1, 4, 5, 6);
    apply(8'hFF, 1, 1, 1);
    chk("flush_ready_ack", ack_one_hot, 8'h00);
    tick();
    expect_bundle(0, 0, 0, 0, 6);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      r = W'($urandom);
      if ($urandom_range(0, 1) == 1) r = r & W'($urandom);
      apply(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
